fb_writer: RTL and testbench
============================

FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter DEPTH, default 16, input FIFO depth in 32-bit words; power of two, at least 8.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; latches base/stride/hwords/vlines and begins a frame.
REQ-005 base  input  23  frame start address in 32-bit words.
REQ-006 stride  input  23  line-to-line address step in words.
REQ-007 hwords  input  9  words per line, 1..256.
REQ-008 vlines  input  12  lines per frame, 1..4095.
REQ-009 pixdata  input  32  input word.
REQ-010 pixvalid  input  1  pixdata valid.
REQ-011 pixready  output  1  word accepted when pixvalid && pixready.
REQ-012 busy  output  1  frame in progress.
REQ-013 done  output  1  one-cycle pulse after the last word of the frame is written.
REQ-014 memaddr  output  23  request word address.
REQ-015 memwdata  output  32  write data to memory port.
REQ-016 memlen  output  2  burst length minus 1.
REQ-017 memwr  output  1  constant 1.
REQ-018 memreq  output  1  request strobe.
REQ-019 memready  input  1  memory port idle; request taken when memreq && memready.
REQ-020 memack  input  1  per-word acknowledge pulse from the memory port.

Function
REQ-021 FIFO: DEPTH words; pixready = busy && FIFO not full; simultaneous push and pop on a full FIFO is not permitted, since pixready is low when full.
REQ-022 FSM states: IDLE, WAIT, REQ, DATA, DONE.
REQ-023 IDLE: on start, latch parameters, set lineaddr=base, addr=base, wordsleft=hwords, lines=vlines, busy=1, then go to WAIT; start is ignored outside IDLE.
REQ-024 WAIT: burst size n = min(4, wordsleft); go to REQ when FIFO count >= n.
REQ-025 REQ: drive memreq=1, memaddr=addr, memlen=n-1, memwdata=FIFO head; on memreq && memready, drop memreq the following cycle and go to DATA.
REQ-026 DATA: acknowledge index k starts at 0 on acceptance.
REQ-027 DATA: the first memack does not pop the FIFO; each later memack pops one word and advances memwdata to the new head.
REQ-028 DATA: after n+1 memack pulses, n words have been popped; then addr += n and wordsleft -= n.
REQ-029 End of line: when wordsleft reaches 0, lineaddr += stride, addr = lineaddr, wordsleft = hwords, lines -= 1.
REQ-030 Exit from DATA: go to DONE if lines reaches 0, else go to WAIT.
REQ-031 DONE: pulse done for one cycle, clear busy, go to IDLE; words arriving afterwards are not accepted.
REQ-032 Bursts never exceed 4 words and never cross a line end; the final burst of a line has n = hwords mod 4 when that value is nonzero.
REQ-033 Address arithmetic is modulo 2^23 (wrap-around permitted, no saturation).
REQ-034 memack received outside DATA is ignored.
REQ-035 memreq is never asserted while in DATA, so at most one outstanding request exists.

Reset
REQ-036 rst asserted at any time, including mid-burst, forces asynchronously: state=IDLE, FIFO empty, memreq=0, pixready=0, busy=0, done=0, memlen=0, memaddr=0, memwdata=0.
REQ-037 A burst interrupted by reset is not resumed; its data is discarded.

Verification
REQ-038 Basic frame: base=0x100, stride=0x200, hwords=8, vlines=2, continuous words 1..16, memready=1, memack per word -> 4 bursts, each memlen=3, at addresses 0x100, 0x104, 0x300, 0x304; data in order; one done pulse.
REQ-039 Partial burst: hwords=6, vlines=1 -> bursts at base with memlen=3, then at base+4 with memlen=1.
REQ-040 Backpressure: memready held low for 50 cycles with words streaming -> FIFO fills, pixready=0 at DEPTH words, no data lost; once memready rises, all DEPTH words are written in order.
REQ-041 Slow source: one word every 10 cycles, hwords=4 -> memreq asserted only after the 4th word is in the FIFO.
REQ-042 Reset mid-DATA after 2 acks -> memreq=0, busy=0, FIFO empty; a new start writes the new frame from its base correctly.
REQ-043 Wrap: base=0x7FFFFE, hwords=4, vlines=1 -> single burst at 0x7FFFFE, memlen=3, done pulses.

Source files
------------

// File: rtl/fb_writer_if.sv
// Pixel stream and memory write-port signals of the frame-buffer writer.
// Handshakes: pixel word moves when pixvalid && pixready; request moves when memreq && memready.
interface fb_writer_if;
  logic [31:0] pixdata;
  logic        pixvalid;
  logic        pixready;
  logic [22:0] memaddr;
  logic [31:0] memwdata;
  logic [1:0]  memlen;
  logic        memwr;
  logic        memreq;
  logic        memready;
  logic        memack;

  modport master (
    input  pixdata, pixvalid, memready, memack,
    output pixready, memaddr, memwdata, memlen, memwr, memreq
  );

  modport slave (
    output pixdata, pixvalid, memready, memack,
    input  pixready, memaddr, memwdata, memlen, memwr, memreq
  );
endinterface

// File: rtl/fb_writer.sv
// Frame-buffer writer: buffers incoming pixel words and writes them out as
// bursts of up to four words, line by line, at base + line*stride.
module fb_writer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [22:0] base,
  input  logic [22:0] stride,
  input  logic [8:0]  hwords,
  input  logic [11:0] vlines,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state,
  fb_writer_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_DATA, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [22:0] stride_q, stride_d;
  logic [8:0]  hwords_q, hwords_d;
  logic [22:0] lineaddr_q, lineaddr_d;
  logic [22:0] addr_q, addr_d;
  logic [8:0]  wordsleft_q, wordsleft_d;
  logic [11:0] lines_q, lines_d;
  logic [2:0]  k_q, k_d;

  logic [31:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic       push, pop, flush, fifo_full;
  logic [2:0] burst_n;

  assign burst_n   = (wordsleft_q >= 9'd4) ? 3'd4 : wordsleft_q[2:0];
  assign fifo_full = (count_q == (AW+1)'(DEPTH));
  assign busy      = (state_q == S_WAIT) || (state_q == S_REQ) || (state_q == S_DATA);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  assign bus.pixready = busy && !fifo_full;
  assign push         = bus.pixvalid && bus.pixready;
  assign bus.memreq   = (state_q == S_REQ);
  assign bus.memlen   = bus.memreq ? 2'(burst_n - 3'd1) : 2'd0;
  assign bus.memaddr  = addr_q;
  // An empty FIFO presents zero so the data bus is clean after reset.
  assign bus.memwdata = (count_q != '0) ? fifo_mem[rd_ptr_q] : 32'd0;
  assign bus.memwr    = 1'b1;

  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    hwords_d    = hwords_q;
    lineaddr_d  = lineaddr_q;
    addr_d      = addr_q;
    wordsleft_d = wordsleft_q;
    lines_d     = lines_q;
    k_d         = k_q;
    pop         = 1'b0;
    flush       = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        stride_d    = stride;
        hwords_d    = hwords;
        lineaddr_d  = base;
        addr_d      = base;
        wordsleft_d = hwords;
        lines_d     = vlines;
        flush       = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: if (count_q >= (AW+1)'(burst_n)) state_d = S_REQ;
      S_REQ: if (bus.memready) begin
        k_d     = 3'd0;
        state_d = S_DATA;
      end
      S_DATA: if (bus.memack) begin
        // The first ack of a burst only opens it; acks 2..n+1 consume words.
        k_d = k_q + 3'd1;
        pop = (k_q != 3'd0);
        if (k_q == burst_n) begin
          if (wordsleft_q == 9'(burst_n)) begin
            lineaddr_d  = lineaddr_q + stride_q;
            addr_d      = lineaddr_q + stride_q;
            wordsleft_d = hwords_q;
            lines_d     = lines_q - 12'd1;
            state_d     = (lines_q == 12'd1) ? S_DONE : S_WAIT;
          end else begin
            addr_d      = addr_q + 23'(burst_n);
            wordsleft_d = wordsleft_q - 9'(burst_n);
            state_d     = S_WAIT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.pixdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stride_q    <= '0;
      hwords_q    <= '0;
      lineaddr_q  <= '0;
      addr_q      <= '0;
      wordsleft_q <= '0;
      lines_q     <= '0;
      k_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      hwords_q    <= hwords_d;
      lineaddr_q  <= lineaddr_d;
      addr_q      <= addr_d;
      wordsleft_q <= wordsleft_d;
      lines_q     <= lines_d;
      k_q         <= k_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end
endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: random frames against a burst/data reference model,
// plus directed backpressure, slow-source, reset and wrap scenarios.
module tb_fb_writer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [22:0] base, stride;
  logic [8:0]  hwords;
  logic [11:0] vlines;
  logic        busy, done;
  logic [2:0]  dbg_state;

  fb_writer_if bus ();

  fb_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .stride(stride),
    .hwords(hwords), .vlines(vlines), .busy(busy), .done(done),
    .dbg_state(dbg_state), .bus(bus.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [24:0] exp_burst_q[$];  // {addr, len}
  logic [31:0] exp_data_q[$];

  int pending = 0;
  int cur_len = 0;
  int acks_total = 0;
  int bursts_seen = 0;
  int rdy_hold = 0;
  bit rdy_rand = 1'b0;
  int done_cnt = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory port model + monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      pending     = 0;
      bus.memack  = 1'b0;
      bus.memready = 1'b0;
    end else begin
      if (pending > 0 && (!rdy_rand || $urandom_range(0, 2) != 0)) begin
        bus.memack = 1'b1;
        if (cur_len + 2 - pending >= 1) begin
          if (exp_data_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wdata_unexpected: got %h expected none", bus.memwdata);
          end else begin
            check("wdata", bus.memwdata, exp_data_q.pop_front());
          end
        end
        pending--;
        acks_total++;
      end else begin
        bus.memack = 1'b0;
      end

      if (rdy_hold > 0) begin
        rdy_hold--;
        bus.memready = 1'b0;
      end else if (pending > 0) begin
        bus.memready = 1'b0;
      end else begin
        bus.memready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end

      if (bus.memreq && bus.memready) begin
        bursts_seen++;
        if (exp_burst_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL burst_unexpected: got addr %h len %0d expected none", bus.memaddr, bus.memlen);
        end else begin
          logic [24:0] e;
          e = exp_burst_q.pop_front();
          check("burst_addr", 32'(bus.memaddr), 32'(e[24:2]));
          check("burst_len", 32'(bus.memlen), 32'(e[1:0]));
        end
        cur_len = int'(bus.memlen);
        pending = cur_len + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        check("done_one_cycle", 32'(done_prev), 32'd0);
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] w);
    int t = 0;
    bus.pixvalid = 1'b1;
    bus.pixdata  = w;
    while (!bus.pixready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_cmp++; n_bad++;
      $display("FAIL pix_timeout: got pixready 0 expected 1");
    end else begin
      exp_data_q.push_back(w);
    end
    @(negedge clk);
    bus.pixvalid = 1'b0;
  endtask

  task automatic model_frame(input logic [22:0] b, input logic [22:0] s,
                             input logic [8:0] hw, input logic [11:0] vl);
    for (int l = 0; l < int'(vl); l++) begin
      logic [22:0] la;
      la = b + 23'(l) * s;
      for (int w = 0; w < int'(hw); w += 4) begin
        int n;
        logic [22:0] a;
        n = (int'(hw) - w >= 4) ? 4 : int'(hw) - w;
        a = la + 23'(w);
        exp_burst_q.push_back({a, 2'(n - 1)});
      end
    end
  endtask

  task automatic pulse_start(input logic [22:0] b, input logic [22:0] s,
                             input logic [8:0] hw, input logic [11:0] vl);
    model_frame(b, s, hw, vl);
    base = b; stride = s; hwords = hw; vlines = vl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);
    check("bursts_left", 32'(exp_burst_q.size()), 32'd0);
    check("words_left", 32'(exp_data_q.size()), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("pixready_after_done", 32'(bus.pixready), 32'd0);
  endtask

  task automatic run_frame(input logic [22:0] b, input logic [22:0] s, input logic [8:0] hw,
                           input logic [11:0] vl, input int gap_max, input bit seq);
    int d0;
    d0 = done_cnt;
    pulse_start(b, s, hw, vl);
    for (int i = 0; i < int'(hw) * int'(vl); i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_word(seq ? 32'(i + 1) : $urandom);
    end
    wait_done(d0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; base = '0; stride = '0; hwords = '0; vlines = '0;
    bus.pixvalid = 1'b0; bus.pixdata = '0; bus.memready = 1'b0; bus.memack = 1'b0;
    #1;
    check("rst_memreq", 32'(bus.memreq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pixready", 32'(bus.pixready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_memaddr", 32'(bus.memaddr), 32'd0);
    check("rst_memlen", 32'(bus.memlen), 32'd0);
    check("rst_memwdata", bus.memwdata, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // basic two-line frame with sequential data
    run_frame(23'h100, 23'h200, 9'd8, 12'd2, 0, 1'b1);
    // partial final burst
    run_frame(23'h1230, 23'h40, 9'd6, 12'd1, 1, 1'b0);

    // backpressure: memory port held off while the FIFO fills
    begin
      int b0, d0;
      b0 = bursts_seen;
      d0 = done_cnt;
      rdy_hold = 55;
      fork
        begin
          pulse_start(23'h4000, 23'h100, 9'd32, 12'd1);
          for (int i = 0; i < 32; i++) send_word($urandom);
        end
        begin
          repeat (42) @(negedge clk);
          check("bp_pixready_full", 32'(bus.pixready), 32'd0);
          check("bp_no_burst", 32'(bursts_seen - b0), 32'd0);
          check("bp_words_held", 32'(exp_data_q.size()), 32'(DEPTH));
        end
      join
      wait_done(d0);
    end

    // slow source: no request until the fourth word is buffered
    begin
      int d0;
      d0 = done_cnt;
      pulse_start(23'h2468, 23'h10, 9'd4, 12'd1);
      for (int i = 0; i < 4; i++) begin
        repeat (10) begin
          @(negedge clk);
          check("slow_no_req", 32'(bus.memreq), 32'd0);
        end
        send_word($urandom);
      end
      @(negedge clk);
      check("slow_req_after_4th", 32'(bus.memreq), 32'd1);
      wait_done(d0);
    end

    // reset in the middle of a burst after two acks
    begin
      int a0, t;
      a0 = acks_total;
      t = 0;
      pulse_start(23'h5000, 23'h80, 9'd8, 12'd2);
      for (int i = 0; i < 4; i++) send_word($urandom);
      while (acks_total < a0 + 2 && t < 1000) begin
        @(negedge clk);
        t++;
      end
      check("rst_test_acks", 32'(acks_total - a0), 32'd2);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_memreq", 32'(bus.memreq), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_pixready", 32'(bus.pixready), 32'd0);
      check("midrst_memwdata", bus.memwdata, 32'd0);
      check("midrst_memaddr", 32'(bus.memaddr), 32'd0);
      exp_burst_q.delete();
      exp_data_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_frame(23'h6100, 23'h20, 9'd7, 12'd2, 1, 1'b0);
    end

    // address wrap-around
    run_frame(23'h7FFFFE, 23'h0, 9'd4, 12'd1, 0, 1'b0);
    run_frame(23'h7FFFF0, 23'h10, 9'd5, 12'd3, 1, 1'b0);

    // random frames with random memory handshake timing
    rdy_rand = 1'b1;
    for (int f = 0; f < 8; f++) begin
      run_frame(23'($urandom), 23'($urandom_range(0, 1024)),
                9'($urandom_range(1, 20)), 12'($urandom_range(1, 4)), 3, 1'b0);
    end
    rdy_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
